data_mem_if: RTL and testbench

- Load/store front end that sits directly upstream of the mem stage and drives the external data SRAM.
- Takes the load/store opcode, effective address and store operand from the EX/MEM boundary.
- Generates size, byte strobes and lane-aligned store data, then runs a request/response handshake with the data bus.
- Holds the pipeline with stallreq_o until the read word is captured; mem_data_o feeds the mem stage's mem_data_i.

---
 rtl/data_mem_if_pkg.sv | 47 ++++
 rtl/data_mem_if_store_align.sv | 62 ++++++
 rtl/data_mem_if.sv | 166 ++++++++++++++++
 tb/tb_data_mem_if.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_if_pkg.sv
// ------------------------------------------------------------------
// data_mem_if_pkg : load/store opcodes, bus size codes, FSM states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package data_mem_if_pkg;

  localparam int ALUOP_W = 8;

  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [ALUOP_W-1:0] EXE_SWR_OP = 8'b1110_1110;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    CANCEL = 3'd4
  } state_e;

  function automatic logic is_load_op(input logic [ALUOP_W-1:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                      EXE_LW_OP, EXE_LWL_OP, EXE_LWR_OP};
  endfunction

  function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP};
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_if_store_align.sv
// ------------------------------------------------------------------
// data_mem_if_store_align : size, byte strobes, lane data, misalignment
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module data_mem_if_store_align
  import data_mem_if_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [31:0]        reg2_i,
  output logic [1:0]         size_o,
  output logic [3:0]         strb_o,
  output logic [31:0]        wdata_o,
  output logic               misaligned_o
);

  always_comb begin
    size_o       = DSIZE_WORD;
    strb_o       = 4'b0000;
    wdata_o      = '0;
    misaligned_o = 1'b0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: size_o = DSIZE_BYTE;
      EXE_LH_OP, EXE_LHU_OP: begin
        size_o       = DSIZE_HALF;
        misaligned_o = addr_lo_i[0];
      end
      EXE_LW_OP: misaligned_o = (addr_lo_i != 2'b00);
      EXE_SB_OP: begin
        size_o  = DSIZE_BYTE;
        strb_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        size_o       = DSIZE_HALF;
        strb_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{reg2_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      EXE_SW_OP: begin
        strb_o       = 4'b1111;
        wdata_o      = reg2_i;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      // Unaligned-word stores: ~addr_lo_i is (3 - a)
      EXE_SWL_OP: begin
        strb_o  = 4'b1111 >> ~addr_lo_i;
        wdata_o = reg2_i >> {~addr_lo_i, 3'b000};
      end
      EXE_SWR_OP: begin
        strb_o  = 4'b1111 << addr_lo_i;
        wdata_o = reg2_i << {addr_lo_i, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_if.sv
// ------------------------------------------------------------------
// data_mem_if : load/store front end driving the data SRAM handshake
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module data_mem_if
  import data_mem_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  reg2_i,
  input  logic               valid_i,
  input  logic               except_i,
  input  logic               flush,
  input  logic               stall_i,
  output logic               data_req,
  output logic               data_wr,
  output logic [1:0]         data_size,
  output logic [ADDR_W-1:0]  data_addr,
  output logic [3:0]         data_wstrb,
  output logic [DATA_W-1:0]  data_wdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok,
  input  logic [DATA_W-1:0]  data_rdata,
  output logic [DATA_W-1:0]  mem_data_o,
  output logic               stallreq_o,
  output logic               adel_o,
  output logic               ades_o
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          strb_q, strb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req;

  logic [1:0]          al_size;
  logic [3:0]          al_strb;
  logic [DATA_W-1:0]   al_wdata;
  logic                al_mis;

  data_mem_if_store_align u_align (
    .aluop_i      (aluop_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .reg2_i       (reg2_i),
    .size_o       (al_size),
    .strb_o       (al_strb),
    .wdata_o      (al_wdata),
    .misaligned_o (al_mis)
  );

  logic              is_ld, is_st, live, memop, in_idle, busy, done_now;
  logic [ADDR_W-1:0] addr_cur;

  assign is_ld    = is_load_op(aluop_i);
  assign is_st    = is_store_op(aluop_i);
  assign live     = valid_i & ~except_i;
  assign memop    = live & (is_ld | is_st) & ~al_mis;
  assign addr_cur = (al_size == DSIZE_WORD) ? {mem_addr_i[ADDR_W-1:2], 2'b00} : mem_addr_i;
  assign in_idle  = (state_q == IDLE);
  assign busy     = (state_q == IDLE) | (state_q == REQ) | (state_q == WAIT);

  always_comb begin
    state_d    = state_q;
    mem_data_d = mem_data_q;
    wr_d       = wr_q;
    size_d     = size_q;
    addr_d     = addr_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    req        = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop && !flush) begin
          req     = 1'b1;
          wr_d    = is_st;
          size_d  = al_size;
          addr_d  = addr_cur;
          strb_d  = al_strb;
          wdata_d = al_wdata;
          if (data_addr_ok && data_data_ok) begin
            state_d = DONE;
            if (!is_st) mem_data_d = data_rdata;
          end else if (data_addr_ok) begin
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (data_addr_ok && data_data_ok) begin
          state_d = flush ? IDLE : DONE;
          if (!flush && !wr_q) mem_data_d = data_rdata;
        end else if (data_addr_ok) begin
          state_d = flush ? CANCEL : WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          state_d = flush ? IDLE : DONE;
          if (!flush && !wr_q) mem_data_d = data_rdata;
        end else if (flush) begin
          state_d = CANCEL;
        end
      end
      DONE: begin
        if (flush || !stall_i) state_d = IDLE;
      end
      // A flushed transaction still owes one response; swallow it here.
      CANCEL: begin
        if (data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_data_q <= '0;
      wr_q       <= 1'b0;
      size_q     <= DSIZE_BYTE;
      addr_q     <= '0;
      strb_q     <= 4'b0000;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_data_q <= mem_data_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
    end
  end

  // In IDLE the request is presented straight from the decode; in REQ it is replayed from the latch.
  assign data_req   = ~rst & req;
  assign data_wr    = data_req & (in_idle ? is_st : wr_q);
  assign data_size  = data_req ? (in_idle ? al_size  : size_q)  : 2'b00;
  assign data_addr  = data_req ? (in_idle ? addr_cur : addr_q)  : '0;
  assign data_wstrb = data_req ? (in_idle ? al_strb  : strb_q)  : 4'b0000;
  assign data_wdata = data_req ? (in_idle ? al_wdata : wdata_q) : '0;

  assign done_now   = (data_req & data_addr_ok & data_data_ok) | ((state_q == WAIT) & data_data_ok);
  assign stallreq_o = ~rst & memop & busy & ~done_now;
  assign mem_data_o = mem_data_q;
  assign adel_o     = ~rst & live & is_ld & al_mis;
  assign ades_o     = ~rst & live & is_st & al_mis;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_if.sv
// ------------------------------------------------------------------
// tb_data_mem_if : randomized self-checking bench with reference model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_data_mem_if;
  import data_mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        valid_i, except_i, flush, stall_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, mem_data_o;
  logic        stallreq_o, adel_o, ades_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int exp_acc = 0;
  logic [31:0] exp_mem = 32'd0;

  data_mem_if dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .valid_i(valid_i), .except_i(except_i), .flush(flush), .stall_i(stall_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_data_o(mem_data_o),
    .stallreq_o(stallreq_o), .adel_o(adel_o), .ades_o(ades_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && data_req && data_addr_ok) n_acc <= n_acc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: bus request fields derived directly from the load/store rules.
  function automatic void model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                                output logic ld, output logic st, output logic mis,
                                output logic [1:0] sz, output logic [31:0] ba,
                                output logic [3:0] sb, output logic [31:0] wd);
    int a;
    a  = int'(addr[1:0]);
    ld = op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LWL_OP, EXE_LWR_OP};
    st = op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP};
    if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP})      sz = 2'd0;
    else if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) sz = 2'd1;
    else                                                   sz = 2'd2;
    mis = (ld || st) && ((sz == 2'd1 && (a % 2) == 1) || (op inside {EXE_LW_OP, EXE_SW_OP} && a != 0));
    ba  = (sz == 2'd2) ? (addr & 32'hFFFF_FFFC) : addr;
    sb  = 4'd0;
    wd  = 32'd0;
    case (op)
      EXE_SB_OP:  begin sb = 4'(1 << a);               wd = r2[7:0] * 32'h0101_0101; end
      EXE_SH_OP:  begin sb = 4'(3 << a);               wd = r2[15:0] * 32'h0001_0001; end
      EXE_SW_OP:  begin sb = 4'hF;                     wd = r2; end
      EXE_SWL_OP: begin sb = 4'((1 << (a + 1)) - 1);   wd = r2 >> (8 * (3 - a)); end
      EXE_SWR_OP: begin sb = 4'(15 << a);              wd = r2 << (8 * a); end
      default: ;
    endcase
  endfunction

  task automatic idle_inputs();
    valid_i = 1'b0; except_i = 1'b0; flush = 1'b0; stall_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
  endtask

  // One instruction: addr_ok after a_dly cycles, data_ok d_dly cycles later, then stall_n held cycles.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic exc, input int a_dly, input int d_dly, input int stall_n);
    logic ld, st, mis;
    logic [1:0] sz;
    logic [31:0] ba, wd, rd;
    logic [3:0] sb;
    model(op, addr, r2, ld, st, mis, sz, ba, sb, wd);
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; except_i = exc; valid_i = 1'b1;
    rd = $urandom;
    if (!(ld || st) || exc || mis) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      chk("adel", 32'(adel_o), 32'(ld & mis & ~exc));
      chk("ades", 32'(ades_o), 32'(st & mis & ~exc));
      chk("noreq", 32'(data_req), 32'd0);
      chk("nostall", 32'(stallreq_o), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      return;
    end
    exp_acc++;
    for (int c = 0; c <= a_dly; c++) begin
      data_addr_ok = (c == a_dly);
      data_data_ok = (c == a_dly) && (d_dly == 0);
      data_rdata   = data_data_ok ? rd : $urandom;
      @(negedge clk);
      chk("req", 32'(data_req), 32'd1);
      chk("wr", 32'(data_wr), 32'(st));
      chk("size", 32'(data_size), 32'(sz));
      chk("addr", data_addr, ba);
      chk("wstrb", 32'(data_wstrb), 32'(sb));
      if (st) chk("wdata", data_wdata, wd);
      chk("stall_req", 32'(stallreq_o), 32'(!data_data_ok));
      if (c == 0) chk("adel_ades", 32'({adel_o, ades_o}), 32'd0);
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0;
    for (int c = 1; c <= d_dly; c++) begin
      data_data_ok = (c == d_dly);
      data_rdata   = data_data_ok ? rd : $urandom;
      @(negedge clk);
      chk("wait_req", 32'(data_req), 32'd0);
      chk("wait_stall", 32'(stallreq_o), 32'(c != d_dly));
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0; data_rdata = $urandom;
    if (ld) exp_mem = rd;
    for (int c = 0; c <= stall_n; c++) begin
      stall_i = (c < stall_n);
      valid_i = (c < stall_n);
      @(negedge clk);
      chk("done_req", 32'(data_req), 32'd0);
      chk("done_stall", 32'(stallreq_o), 32'd0);
      chk("mem_data", mem_data_o, exp_mem);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  logic [7:0] ops [13] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LWL_OP,
                           EXE_LWR_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP,
                           8'h25};

  initial begin
    rst = 1'b1;
    idle_inputs();
    aluop_i = EXE_LH_OP; mem_addr_i = 32'h3001; reg2_i = 32'h0; valid_i = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_outs", 32'({data_wr, data_size, data_wstrb, stallreq_o, adel_o, ades_o}), 32'd0);
    chk("rst_addr", data_addr | data_wdata, 32'd0);
    chk("rst_mem", mem_data_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;

    // Directed cases
    run_op(EXE_LW_OP, 32'h1000, 32'h0, 1'b0, 0, 1, 0);
    chk("lw_data", mem_data_o, 32'hDEAD_BEEF & 32'h0 | exp_mem);
    run_op(EXE_SB_OP, 32'h2003, 32'h0000_00A5, 1'b0, 0, 1, 0);
    run_op(EXE_SWR_OP, 32'h2001, 32'h1122_3344, 1'b0, 1, 0, 0);
    run_op(EXE_LH_OP, 32'h3001, 32'h0, 1'b0, 0, 0, 0);
    run_op(EXE_SW_OP, 32'h3002, 32'h0, 1'b0, 0, 0, 0);
    run_op(EXE_LW_OP, 32'h4004, 32'h0, 1'b0, 3, 1, 0);

    // Flush while waiting for the response
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h5000; valid_i = 1'b1; data_addr_ok = 1'b1;
    exp_acc++;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fl_req0", 32'(data_req), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("fl_req1", 32'(data_req), 32'd0);
    chk("fl_stall1", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0; valid_i = 1'b1; mem_addr_i = 32'h5004;
    @(negedge clk);
    chk("fl_req2", 32'(data_req), 32'd0);
    chk("fl_stall2", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("fl_mem", mem_data_o, exp_mem);
    @(posedge clk); #1;
    run_op(EXE_LW_OP, 32'h5004, 32'h0, 1'b0, 0, 1, 0);

    // Long downstream stall: exactly one bus transaction
    run_op(EXE_LBU_OP, 32'h6002, 32'h0, 1'b0, 0, 1, 4);
    chk("acc_count", 32'(n_acc), 32'(exp_acc));

    // Asynchronous reset in the middle of a request
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h7000; valid_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", 32'(data_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(data_req), 32'd0);
    chk("arst_stall", 32'(stallreq_o), 32'd0);
    chk("arst_mem", mem_data_o, 32'd0);
    exp_mem = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      run_op(ops[$urandom_range(0, 12)], $urandom, $urandom, ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    @(posedge clk); #1;
    chk("acc_final", 32'(n_acc), 32'(exp_acc));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
